// File: rtl/branch_resolve_tracker.sv
// In-order tracker of predicted branches: matches each prediction against the
// EX outcome and raises a one-cycle redirect when the predictor chose wrong.
module branch_resolve_tracker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic                     decision,
  input  logic [PC_W-1:0]          alt_pc,
  output logic                     pred_ready,
  input  logic                     predictor_flush,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     wrong_decision,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [CNT_W-1:0]         mispredict_cnt,
  output logic                     underflow_err
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_W + 1;

  logic            dec_q [DEPTH];
  logic [PC_W-1:0] alt_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;

  logic has_entry, do_pop, mis, do_push, clear_all, underflow_hit;

  // Resolve/push decode; a mispredict or flush wipes the queue and blocks the push.
  always_comb begin
    has_entry     = (inflight != '0);
    do_pop        = res_valid & has_entry;
    mis           = do_pop & (res_taken ^ dec_q[head_q]);
    underflow_hit = res_valid & ~has_entry;
    pred_ready    = (inflight < CNT_BITS'(DEPTH)) | (do_pop & ~mis);
    clear_all     = mis | predictor_flush;
    do_push       = pred_valid & pred_ready & ~clear_all;
  end

  // Entry storage needs no reset; validity is carried by the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      dec_q[tail_q] <= decision;
      alt_q[tail_q] <= alt_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      inflight <= '0;
    end else if (clear_all) begin
      head_q   <= '0;
      tail_q   <= '0;
      inflight <= '0;
    end else begin
      if (do_pop)  head_q <= head_q + PTR_W'(1);
      if (do_push) tail_q <= tail_q + PTR_W'(1);
      inflight <= inflight + CNT_BITS'(do_push) - CNT_BITS'(do_pop);
    end
  end

  // Misprediction report, saturating statistics and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrong_decision <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
      underflow_err  <= 1'b0;
    end else begin
      wrong_decision <= mis;
      if (mis) redirect_pc <= alt_q[head_q];
      if (mis && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      if (underflow_hit) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Bench for branch_resolve_tracker: directed table, hand sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_branch_resolve_tracker;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pred_valid = 1'b0, decision = 1'b0, predictor_flush = 1'b0;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] alt_pc = '0;

  logic        pred_ready, wrong_decision, underflow_err;
  logic [31:0] redirect_pc;
  logic [2:0]  inflight;
  logic [15:0] mispredict_cnt;

  logic        s_pred_ready, s_wrong_decision, s_underflow_err;
  logic [31:0] s_redirect_pc;
  logic [2:0]  s_inflight;
  logic [1:0]  s_mispredict_cnt;

  branch_resolve_tracker #(.DEPTH(DEPTH), .PC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .decision(decision),
    .alt_pc(alt_pc), .pred_ready(pred_ready), .predictor_flush(predictor_flush),
    .res_valid(res_valid), .res_taken(res_taken), .wrong_decision(wrong_decision),
    .redirect_pc(redirect_pc), .inflight(inflight), .mispredict_cnt(mispredict_cnt),
    .underflow_err(underflow_err)
  );

  // Narrow-counter instance on the same stimulus, for saturation.
  branch_resolve_tracker #(.DEPTH(DEPTH), .PC_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .decision(decision),
    .alt_pc(alt_pc), .pred_ready(s_pred_ready), .predictor_flush(predictor_flush),
    .res_valid(res_valid), .res_taken(res_taken), .wrong_decision(s_wrong_decision),
    .redirect_pc(s_redirect_pc), .inflight(s_inflight), .mispredict_cnt(s_mispredict_cnt),
    .underflow_err(s_underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic dec; logic [31:0] alt; } ent_t;
  ent_t        mq[$];
  logic        m_wd, m_uf;
  logic [31:0] m_rdr;
  int          m_cnt;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wd = 1'b0; m_uf = 1'b0; m_rdr = '0; m_cnt = 0;
  endtask

  // Apply one cycle of inputs (called at posedge+1), check readiness before the
  // edge and every registered output after it.
  task automatic step(input logic pv, input logic dec, input logic [31:0] apc,
                      input logic fl, input logic rv, input logic rt);
    logic m_empty, m_mis, exp_ready;
    ent_t e;
    pred_valid = pv; decision = dec; alt_pc = apc;
    predictor_flush = fl; res_valid = rv; res_taken = rt;
    #1;
    m_empty   = (mq.size() == 0);
    m_mis     = rv && !m_empty && (rt != mq[0].dec);
    exp_ready = (mq.size() < DEPTH) || (rv && !m_empty && !m_mis);
    chk("pred_ready", 32'(pred_ready), 32'(exp_ready));
    @(posedge clk);
    #1;
    if (rv && m_empty) m_uf = 1'b1;
    m_wd = m_mis;
    if (m_mis) begin
      m_rdr = mq[0].alt;
      m_cnt++;
    end
    if (fl || m_mis) mq.delete();
    else begin
      if (rv && !m_empty) void'(mq.pop_front());
      if (pv && exp_ready) begin
        e.dec = dec; e.alt = apc;
        mq.push_back(e);
      end
    end
    chk("inflight", 32'(inflight), 32'(mq.size()));
    chk("wrong_decision", 32'(wrong_decision), 32'(m_wd));
    if (m_wd) chk("redirect_pc", redirect_pc, m_rdr);
    chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_cnt));
    chk("mispredict_cnt_sat", 32'(s_mispredict_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
    chk("underflow_err", 32'(underflow_err), 32'(m_uf));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic dec_of(input int i);
    return (i % 3) == 0;
  endfunction

  typedef struct {
    logic pv; logic dec; logic [31:0] alt; logic fl; logic rv; logic rt;
    logic e_wd; int e_inf; logic [31:0] e_rdr; int e_cnt;
  } vec_t;
  vec_t tbl[16];

  initial begin
    // pv dec alt fl rv rt | wd inflight redirect cnt
    tbl[0]  = '{1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h0,   0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 0, 32'h0,   0};
    tbl[2]  = '{1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h0,   0};
    tbl[3]  = '{1'b1, 1'b1, 32'h30C, 1'b0, 1'b0, 1'b0, 1'b0, 2, 32'h0,   0};
    tbl[4]  = '{1'b1, 1'b0, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0, 3, 32'h0,   0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 0, 32'h200, 1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0,   1};
    tbl[7]  = '{1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h0,   1};
    tbl[8]  = '{1'b1, 1'b0, 32'h600, 1'b0, 1'b1, 1'b0, 1'b1, 0, 32'h500, 2};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0,   2};
    tbl[10] = '{1'b1, 1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h0,   2};
    tbl[11] = '{1'b1, 1'b0, 32'h800, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'h0,   2};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0,   2};
    tbl[13] = '{1'b1, 1'b0, 32'h900, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h0,   2};
    tbl[14] = '{1'b1, 1'b0, 32'h910, 1'b1, 1'b1, 1'b1, 1'b1, 0, 32'h900, 3};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0,   3};

    model_reset();
    #12;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_pred_ready", 32'(pred_ready), 32'd1);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_underflow", 32'(underflow_err), 32'd0);

    // Asynchronous reset with three entries in flight
    step(1'b1, 1'b0, 32'hA0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hA4, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hA8, 1'b0, 1'b0, 1'b0);
    pred_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_inflight", 32'(inflight), 32'd0);
    chk("async_pred_ready", 32'(pred_ready), 32'd1);
    chk("async_wrong_decision", 32'(wrong_decision), 32'd0);
    chk("async_cnt", 32'(mispredict_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].pv, tbl[i].dec, tbl[i].alt, tbl[i].fl, tbl[i].rv, tbl[i].rt);
      chk("tbl_wd", 32'(wrong_decision), 32'(tbl[i].e_wd));
      chk("tbl_inflight", 32'(inflight), 32'(tbl[i].e_inf));
      if (tbl[i].e_wd) chk("tbl_redirect", redirect_pc, tbl[i].e_rdr);
      chk("tbl_cnt", 32'(mispredict_cnt), 32'(tbl[i].e_cnt));
    end
    chk("sat_cnt_at_3", 32'(s_mispredict_cnt), 32'd3);

    // Fill, overflow attempt, then push+pop across pointer wrap
    for (int i = 0; i < 4; i++) step(1'b1, dec_of(i), 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b0);
    pred_valid = 1'b0;
    #1;
    chk("full_pred_ready", 32'(pred_ready), 32'd0);
    step(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("full_push_ignored", 32'(inflight), 32'd4);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, dec_of(i + 4), 32'h1000 + 32'(i + 4), 1'b0, 1'b1, dec_of(i));
      chk("wrap_inflight", 32'(inflight), 32'd4);
      chk("wrap_no_pulse", 32'(wrong_decision), 32'd0);
    end
    for (int i = 8; i < 12; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, dec_of(i));
    chk("drain_inflight", 32'(inflight), 32'd0);
    chk("drain_cnt", 32'(mispredict_cnt), 32'd3);

    // Underflow is sticky
    chk("pre_underflow", 32'(underflow_err), 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("underflow_set", 32'(underflow_err), 32'd1);
    chk("underflow_no_pulse", 32'(wrong_decision), 32'd0);
    idle(); idle();
    chk("underflow_sticky", 32'(underflow_err), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 6, 1'($urandom), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4, 1'($urandom));
    end
    chk("final_sat_cnt", 32'(s_mispredict_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
